// File: rtl/lcd_arb_pkg.sv
// rtl/lcd_arb_pkg.sv - shared types, sizes and defaults for the LCD write arbiter
// Contents: state_t (IDLE/SEND/DELAY), N_REQ, IDX_W, default DLY_CYCLES/TIMEOUT,
//           one-hot <-> index helpers.
package lcd_arb_pkg;

  localparam int N_REQ = 3;
  localparam int IDX_W = 2;

  localparam int unsigned DEF_DLY_CYCLES = 262143;
  localparam int unsigned DEF_TIMEOUT    = 4096;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEND  = 2'd1,
    ST_DELAY = 2'd2
  } state_t;

  function automatic logic [IDX_W-1:0] oh_to_idx(input logic [N_REQ-1:0] oh);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (oh[i]) r = IDX_W'(i);
    end
    return r;
  endfunction

  function automatic logic [N_REQ-1:0] idx_to_oh(input logic [IDX_W-1:0] idx);
    logic [N_REQ-1:0] r;
    r = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (idx == IDX_W'(i)) r[i] = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/lcd_rr_pick.sv
// rtl/lcd_rr_pick.sv - combinational round-robin winner selection
// Ports: req  in  N_REQ  pending requests
//        last in  IDX_W  most recently granted index
//        pick out N_REQ  one-hot winner (zero when no request)
module lcd_rr_pick
  import lcd_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last,
  output logic [N_REQ-1:0] pick
);

  logic [IDX_W-1:0] idx;

  // Walk from lowest priority (last itself) up to highest (last+1); the
  // final hit overwrites earlier ones, so the highest-priority request wins.
  always_comb begin
    pick = '0;
    idx  = '0;
    for (int off = N_REQ; off >= 1; off--) begin
      idx = IDX_W'((int'(last) + off) % N_REQ);
      if (req[idx]) begin
        pick      = '0;
        pick[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lcd_write_arbiter.sv
// rtl/lcd_write_arbiter.sv - round-robin arbiter of three LCD write requesters
// Ports: iCLK, reset (async, active-high)
//        req/req_rs/req_data  per-requester request, RS bit and byte
//        gnt/done             one-hot accept / completion pulses
//        busy, timeout_err    status (timeout_err is sticky)
//        lcd_data/lcd_rs/lcd_start/lcd_done  LCD controller handshake
module lcd_write_arbiter
  import lcd_arb_pkg::*;
#(
  parameter int unsigned DLY_CYCLES = DEF_DLY_CYCLES,
  parameter int unsigned TIMEOUT    = DEF_TIMEOUT
) (
  input  logic               iCLK,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ-1:0]   req_rs,
  input  logic [8*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]   gnt,
  output logic [N_REQ-1:0]   done,
  output logic               busy,
  output logic               timeout_err,
  output logic [7:0]         lcd_data,
  output logic               lcd_rs,
  output logic               lcd_start,
  input  logic               lcd_done
);

  // Sized to hold the parameter value itself so neither counter can wrap.
  localparam int DW = (DLY_CYCLES > 0) ? $clog2(DLY_CYCLES + 1) : 1;
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  state_t           state;
  logic [IDX_W-1:0] last_idx;
  logic [DW-1:0]    dly_cnt;
  logic [TW-1:0]    tmo_cnt;

  logic [N_REQ-1:0] pick;
  logic [IDX_W-1:0] pick_idx;
  logic [7:0]       pick_data;
  logic             pick_rs;
  logic             dly_last;
  logic             tmo_last;

  lcd_rr_pick u_pick (
    .req  (req),
    .last (last_idx),
    .pick (pick)
  );

  always_comb begin
    pick_data = '0;
    pick_rs   = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick[i]) begin
        pick_data = req_data[8*i +: 8];
        pick_rs   = req_rs[i];
      end
    end
  end

  assign pick_idx = oh_to_idx(pick);

  // Counters hold (cycles spent) - 1 in the current state.
  assign dly_last = (32'(dly_cnt) + 32'd1) >= DLY_CYCLES;
  assign tmo_last = (32'(tmo_cnt) + 32'd1) >= TIMEOUT;

  always_ff @(posedge iCLK or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      busy        <= 1'b0;
      gnt         <= '0;
      done        <= '0;
      lcd_start   <= 1'b0;
      lcd_data    <= '0;
      lcd_rs      <= 1'b0;
      timeout_err <= 1'b0;
      last_idx    <= IDX_W'(N_REQ - 1);
      dly_cnt     <= '0;
      tmo_cnt     <= '0;
    end else begin
      gnt  <= '0;
      done <= '0;
      unique case (state)
        ST_IDLE: begin
          if (|req) begin
            gnt       <= pick;
            lcd_data  <= pick_data;
            lcd_rs    <= pick_rs;
            lcd_start <= 1'b1;
            last_idx  <= pick_idx;
            dly_cnt   <= '0;
            tmo_cnt   <= '0;
            busy      <= 1'b1;
            state     <= ST_SEND;
          end
        end
        ST_SEND: begin
          // A completion on the timeout edge still counts as a completion.
          if (lcd_done || tmo_last) begin
            lcd_start <= 1'b0;
            if (lcd_done) done <= idx_to_oh(last_idx);
            else          timeout_err <= 1'b1;
            if (DLY_CYCLES == 0) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end else begin
              state <= ST_DELAY;
            end
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        ST_DELAY: begin
          if (dly_last) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            dly_cnt <= dly_cnt + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/lcd_write_arbiter.md
LCD_WRITE_ARBITER -- requirements
Module: lcd_write_arbiter

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-002 The block SHALL expose these parameters:
- DLY_CYCLES, default 262143, idle gap in cycles after each LCD write.
- TIMEOUT, default 4096, maximum cycles to wait for lcd_done.
REQ-003 The block SHALL expose these ports:
- iCLK  in  1  clock.
- reset  in  1  asynchronous active-high reset.
- req  in  3  per-requester write request, held until granted.
- req_rs  in  3  per-requester RS bit (0 = command, 1 = data).
- req_data  in  24  per-requester byte; requester k uses bits [8k+7:8k].
- gnt  out  3  one-hot, one-cycle pulse when requester k is accepted.
- done  out  3  one-hot, one-cycle pulse when requester k's write completes.
- busy  out  1  high in any state other than IDLE.
- timeout_err  out  1  sticky; set on a write that times out.
- lcd_data  out  8  byte to the LCD controller (its iDATA).
- lcd_rs  out  1  RS to the LCD controller (its iRS).
- lcd_start  out  1  start strobe to the LCD controller (its iStart).
- lcd_done  in  1  completion from the LCD controller (its oDone).

Function
REQ-004 The FSM SHALL have exactly three states: IDLE, SEND, DELAY.
REQ-005 In IDLE, if any req bit is high, the block SHALL at the next edge:
- pick winner k round-robin;
- register lcd_data, lcd_rs from requester k;
- set lcd_start=1 and gnt[k]=1;
- enter SEND.
This gives 1-cycle latency from req to lcd_start.
REQ-006 Round-robin order SHALL be last+1, last+2, last (mod 3), where "last" is the most recently granted index.
REQ-007 lcd_data and lcd_rs SHALL stay stable from grant until return to IDLE; later req_data changes SHALL be ignored.
REQ-008 In SEND, lcd_start SHALL stay 1 until lcd_done is sampled high, including in the first SEND cycle. On that edge:
- lcd_start <= 0;
- done[k] pulses;
- state -> DELAY.
REQ-009 In SEND, if lcd_done has not been seen after TIMEOUT cycles, the block SHALL at that edge:
- set lcd_start <= 0;
- set timeout_err <= 1;
- not pulse done;
- enter DELAY.
REQ-010 DELAY SHALL last exactly DLY_CYCLES cycles, then return to IDLE. If DLY_CYCLES=0, SEND SHALL go directly to IDLE.
REQ-011 No grant SHALL be issued in SEND or DELAY; req bits high during those states SHALL be held pending.
REQ-012 Request rules:
- A requester MAY drop req before grant (withdrawal), with no side effect.
- A requester holding req high after gnt SHALL be treated as a new request.
REQ-013 If lcd_done is high in IDLE or DELAY, it SHALL be ignored.
REQ-014 The delay counter and timeout counter SHALL each be wide enough for their parameter values with no wrap, and SHALL both clear on entry to SEND.
REQ-015 gnt and done SHALL never have more than one bit set, and SHALL never be high in the same cycle.

Reset
REQ-016 Reset SHALL immediately force:
- state = IDLE; busy = 0;
- gnt = 0, done = 0;
- lcd_start = 0, lcd_data = 0x00, lcd_rs = 0;
- timeout_err = 0;
- last pointer = 2, so requester 0 wins first;
- both counters = 0.
REQ-017 Reset asserted mid-SEND or mid-DELAY SHALL abandon the write with no done pulse. The first grant after release SHALL follow REQ-005 with pointer = 2.

Structure
REQ-018 A shared package lcd_arb_pkg SHALL hold:
- the state enumeration;
- N_REQ=3;
- default DLY_CYCLES and TIMEOUT.
REQ-019 Round-robin selection SHALL be one combinational sub-module, lcd_rr_pick: inputs req and last, output one-hot pick.

Verification
REQ-020 Single write: DLY_CYCLES=4. req=001, req_data[7:0]=0x38, rs=0 -> next cycle gnt=001, lcd_start=1, lcd_data=0x38, lcd_rs=0. lcd_done high 3 cycles later -> done=001, lcd_start=0. busy falls exactly 4 cycles after done.
REQ-021 Fairness: all three req held high from reset -> grant order 0, 1, 2, 0, 1, 2, with gnt never during SEND or DELAY.
REQ-022 Timeout: TIMEOUT=16, lcd_done held 0 -> lcd_start drops after 16 SEND cycles, timeout_err=1 and stays 1, no done pulse. The next request is still serviced.
REQ-023 Withdrawal and simultaneous events:
- req[1] pulses high for one cycle during DELAY -> no gnt[1].
- req=110 arriving in IDLE after a grant to 1 -> gnt=100.
REQ-024 Reset mid-operation: reset asserted in SEND -> lcd_start=0 immediately, no done. After release, req=111 -> gnt=001.
REQ-025 Zero delay: DLY_CYCLES=0, req=001 held -> back-to-back writes with exactly one IDLE cycle between the done pulse and the next lcd_start rise.
